// File: rtl/vga_sprite_compositor.sv
// vga_sprite_compositor
//   VGA timing generator plus a fixed-priority sprite compositor for the game
//   display path. A free-running h/v raster counter produces sync, blank and
//   pixel coordinates. NUM_SPR fixed-size sprites are overlaid on a background
//   colour, with sprite 0 having the highest priority. A per-frame
//   bounding-box collision mask is also latched.
//
//   Pipeline (each stage advances only on pix_en_i):
//     counters -> stage 0 (coordinates, sprite hits) -> stage 1 (colour, syncs)
//   The texel/background sources answer the stage-0 coordinates one pix_en
//   later, which is exactly when stage 1 consumes them.
//
// Ports
//   clk            system clock
//   rst            asynchronous, active-low reset
//   pix_en_i       pixel-rate enable; all state holds while low
//   spr_x_i        packed sprite left edges, sprite i at [i*XW +: XW]
//   spr_y_i        packed sprite top edges, sprite i at [i*YW +: YW]
//   spr_en_i       per-sprite visible/collidable enable
//   spr_rgb_i      packed sprite texel colours for the previously issued pixel
//   bg_rgb_i       background colour for the previously issued pixel
//   pix_x_o        current active column (0 outside active video)
//   pix_y_o        current active row (0 outside active video)
//   spr_lx_o       packed sprite-local texel columns (X - spr_x)
//   spr_ly_o       packed sprite-local texel rows (Y - spr_y)
//   vga_hs_o       horizontal sync, aligned with vga_rgb_o
//   vga_vs_o       vertical sync, aligned with vga_rgb_o
//   vga_blank_n_o  high during active video, aligned with vga_rgb_o
//   vga_rgb_o      composited pixel colour {R,G,B}
//   frame_start_o  one-pixel pulse when pixel (0,0) is issued
//   frame_done_o   one-pixel pulse on the first pixel after the last active one
//   coll_mask_o    sprites that overlapped another sprite in the last frame

module vga_sprite_compositor #(
    parameter int          NUM_SPR  = 4,
    parameter int          SPR_W    = 20,
    parameter int          SPR_H    = 20,
    parameter int          H_ACT    = 640,
    parameter int          H_FP     = 16,
    parameter int          H_SYNC   = 96,
    parameter int          H_BP     = 48,
    parameter int          V_ACT    = 480,
    parameter int          V_FP     = 10,
    parameter int          V_SYNC   = 2,
    parameter int          V_BP     = 33,
    parameter logic        SYNC_POL = 1'b0,
    parameter int          XW       = 10,
    parameter int          YW       = 9,
    parameter logic [23:0] TRANSP   = 24'hFF00FF
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 pix_en_i,
    input  logic [NUM_SPR*XW-1:0]                spr_x_i,
    input  logic [NUM_SPR*YW-1:0]                spr_y_i,
    input  logic [NUM_SPR-1:0]                   spr_en_i,
    input  logic [NUM_SPR*24-1:0]                spr_rgb_i,
    input  logic [23:0]                          bg_rgb_i,
    output logic [XW-1:0]                        pix_x_o,
    output logic [YW-1:0]                        pix_y_o,
    output logic [NUM_SPR*$clog2(SPR_W)-1:0]     spr_lx_o,
    output logic [NUM_SPR*$clog2(SPR_H)-1:0]     spr_ly_o,
    output logic                                 vga_hs_o,
    output logic                                 vga_vs_o,
    output logic                                 vga_blank_n_o,
    output logic [23:0]                          vga_rgb_o,
    output logic                                 frame_start_o,
    output logic                                 frame_done_o,
    output logic [NUM_SPR-1:0]                   coll_mask_o
);

    localparam int H_TOTAL = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP;
    localparam int HCW     = $clog2(H_TOTAL);
    localparam int VCW     = $clog2(V_TOTAL);
    localparam int LXW     = $clog2(SPR_W);
    localparam int LYW     = $clog2(SPR_H);

    logic [HCW-1:0]         h_q, h_d;
    logic [VCW-1:0]         v_q, v_d;

    logic [31:0]            hc, vc;
    logic [XW-1:0]          hx;
    logic [YW-1:0]          vy;
    logic                   act_c, hsync_c, vsync_c;
    logic [NUM_SPR-1:0]     hit_c;
    logic [NUM_SPR*LXW-1:0] lx_c;
    logic [NUM_SPR*LYW-1:0] ly_c;

    logic [XW-1:0]          pix_x_q;
    logic [YW-1:0]          pix_y_q;
    logic [NUM_SPR*LXW-1:0] lx_q;
    logic [NUM_SPR*LYW-1:0] ly_q;
    logic [NUM_SPR-1:0]     hit_q;
    logic                   act_q, hsync_q, vsync_q;
    logic                   frame_start_q, frame_done_q;

    logic [23:0]            rgb_d, rgb_q;
    logic                   hs_q, vs_q, blank_n_q;
    logic                   multi;
    logic [NUM_SPR-1:0]     acc_d, acc_q, coll_q;

    // Raster counter: h runs across the full line, v steps once per line.
    always_comb begin
        h_d = h_q + HCW'(1);
        v_d = v_q;
        if (h_q == HCW'(H_TOTAL - 1)) begin
            h_d = '0;
            v_d = (v_q == VCW'(V_TOTAL - 1)) ? '0 : v_q + VCW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_q <= '0;
            v_q <= '0;
        end else if (pix_en_i) begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    // Stage 0 decode. Hits are only possible inside active video, where the
    // counters fit the sprite coordinate width; the right/bottom edge sums
    // carry one extra bit so a sprite near the edge never wraps to column 0.
    always_comb begin
        hc      = 32'(h_q);
        vc      = 32'(v_q);
        hx      = XW'(h_q);
        vy      = YW'(v_q);
        act_c   = (hc < H_ACT) && (vc < V_ACT);
        hsync_c = (hc >= H_ACT + H_FP) && (hc < H_ACT + H_FP + H_SYNC);
        vsync_c = (vc >= V_ACT + V_FP) && (vc < V_ACT + V_FP + V_SYNC);
        hit_c   = '0;
        lx_c    = '0;
        ly_c    = '0;
        for (int i = 0; i < NUM_SPR; i++) begin
            hit_c[i] = spr_en_i[i] && act_c
                && (hx >= spr_x_i[i*XW +: XW])
                && ({1'b0, hx} < ({1'b0, spr_x_i[i*XW +: XW]} + (XW+1)'(SPR_W)))
                && (vy >= spr_y_i[i*YW +: YW])
                && ({1'b0, vy} < ({1'b0, spr_y_i[i*YW +: YW]} + (YW+1)'(SPR_H)));
            lx_c[i*LXW +: LXW] = LXW'(hx - spr_x_i[i*XW +: XW]);
            ly_c[i*LYW +: LYW] = LYW'(vy - spr_y_i[i*YW +: YW]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            lx_q          <= '0;
            ly_q          <= '0;
            hit_q         <= '0;
            act_q         <= 1'b0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
        end else if (pix_en_i) begin
            pix_x_q       <= act_c ? hx : '0;
            pix_y_q       <= act_c ? vy : '0;
            lx_q          <= lx_c;
            ly_q          <= ly_c;
            hit_q         <= hit_c;
            act_q         <= act_c;
            hsync_q       <= hsync_c;
            vsync_q       <= vsync_c;
            frame_start_q <= (hc == 0) && (vc == 0);
            frame_done_q  <= (hc == H_ACT) && (vc == V_ACT - 1);
        end
    end

    // Stage 1 compositing: the loop runs from lowest to highest priority so
    // the last opaque hit written (lowest index) wins. Collision uses the
    // bounding-box hits only; x & (x-1) is non-zero exactly when two or more
    // sprites are hit.
    always_comb begin
        rgb_d = bg_rgb_i;
        for (int i = NUM_SPR - 1; i >= 0; i--) begin
            if (hit_q[i] && (spr_rgb_i[i*24 +: 24] != TRANSP)) begin
                rgb_d = spr_rgb_i[i*24 +: 24];
            end
        end
        if (!act_q) begin
            rgb_d = '0;
        end
        multi = |(hit_q & (hit_q - NUM_SPR'(1)));
        acc_d = acc_q | (multi ? hit_q : '0);
    end

    // The frame_done pixel is outside active video, so its own hits are
    // empty and the accumulator already holds the whole frame's overlaps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rgb_q     <= '0;
            hs_q      <= ~SYNC_POL;
            vs_q      <= ~SYNC_POL;
            blank_n_q <= 1'b0;
            acc_q     <= '0;
            coll_q    <= '0;
        end else if (pix_en_i) begin
            rgb_q     <= rgb_d;
            hs_q      <= hsync_q ? SYNC_POL : ~SYNC_POL;
            vs_q      <= vsync_q ? SYNC_POL : ~SYNC_POL;
            blank_n_q <= act_q;
            if (frame_done_q) begin
                coll_q <= acc_d;
                acc_q  <= '0;
            end else begin
                acc_q  <= acc_d;
            end
        end
    end

    assign pix_x_o       = pix_x_q;
    assign pix_y_o       = pix_y_q;
    assign spr_lx_o      = lx_q;
    assign spr_ly_o      = ly_q;
    assign frame_start_o = frame_start_q;
    assign frame_done_o  = frame_done_q;
    assign vga_rgb_o     = rgb_q;
    assign vga_hs_o      = hs_q;
    assign vga_vs_o      = vs_q;
    assign vga_blank_n_o = blank_n_q;
    assign coll_mask_o   = coll_q;

endmodule

// File: tb/tb_vga_sprite_compositor.sv
// tb_vga_sprite_compositor
//   Bench for vga_sprite_compositor using a shrunken raster (80x38 total,
//   64x32 active) so several whole frames fit in a short run. The expected
//   outputs come from the raster position implied by the number of pix_en
//   pulses since reset, with sprite hits and colours derived arithmetically.

module tb_vga_sprite_compositor;

    localparam int NS = 3;
    localparam int SW = 8;
    localparam int SH = 6;
    localparam int HA = 64;
    localparam int HF = 4;
    localparam int HS = 8;
    localparam int HB = 4;
    localparam int VA = 32;
    localparam int VF = 2;
    localparam int VS = 2;
    localparam int VB = 2;
    localparam int XW = 6;
    localparam int YW = 5;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int FD = (VA - 1) * HT + HA;
    localparam logic [23:0] TR = 24'hFF00FF;

    logic              clk = 1'b0;
    logic              rst;
    logic              pix_en;
    logic [NS*XW-1:0]  spr_x;
    logic [NS*YW-1:0]  spr_y;
    logic [NS-1:0]     spr_en;
    logic [NS*24-1:0]  spr_rgb;
    logic [23:0]       bg_rgb;
    logic [XW-1:0]     pix_x;
    logic [YW-1:0]     pix_y;
    logic [NS*3-1:0]   spr_lx;
    logic [NS*3-1:0]   spr_ly;
    logic              vga_hs, vga_vs, vga_blank_n;
    logic [23:0]       vga_rgb;
    logic              frame_start, frame_done;
    logic [NS-1:0]     coll_mask;

    int                sx [NS];
    int                sy [NS];
    logic              en [NS];
    logic [23:0]       sprRgb [NS];
    logic [23:0]       bgCol;

    int                checks = 0;
    int                errors = 0;
    int                np = 0;
    int                cur = 0;
    int                epoch = 0;

    vga_sprite_compositor #(
        .NUM_SPR(NS), .SPR_W(SW), .SPR_H(SH),
        .H_ACT(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACT(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1'b0), .XW(XW), .YW(YW), .TRANSP(TR)
    ) dut (
        .clk(clk), .rst(rst), .pix_en_i(pix_en),
        .spr_x_i(spr_x), .spr_y_i(spr_y), .spr_en_i(spr_en),
        .spr_rgb_i(spr_rgb), .bg_rgb_i(bg_rgb),
        .pix_x_o(pix_x), .pix_y_o(pix_y),
        .spr_lx_o(spr_lx), .spr_ly_o(spr_ly),
        .vga_hs_o(vga_hs), .vga_vs_o(vga_vs), .vga_blank_n_o(vga_blank_n),
        .vga_rgb_o(vga_rgb),
        .frame_start_o(frame_start), .frame_done_o(frame_done),
        .coll_mask_o(coll_mask)
    );

    always #5 clk = ~clk;

    // Single comparison point: every mismatch is reported and counted here.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Copy the bench-side sprite/colour state onto the DUT inputs.
    task automatic applyStimulus();
        for (int i = 0; i < NS; i++) begin
            spr_x[i*XW +: XW]  = XW'(sx[i]);
            spr_y[i*YW +: YW]  = YW'(sy[i]);
            spr_en[i]          = en[i];
            spr_rgb[i*24 +: 24] = sprRgb[i];
        end
        bg_rgb = bgCol;
    endtask

    // Sprite placement for each frame of the first run; other frames random.
    task automatic setScenario(input int f);
        for (int i = 0; i < NS; i++) begin
            sx[i] = 0;
            sy[i] = 0;
            en[i] = 1'b0;
        end
        case (f)
            0: begin sx[0] = 10; sy[0] = 5; en[0] = 1'b1; end
            1: begin
                sx[0] = 30; sy[0] = 12; en[0] = 1'b1;
                sx[1] = 30; sy[1] = 12; en[1] = 1'b1;
            end
            2: begin en[0] = 1'b1; sx[1] = 8; en[1] = 1'b1; end
            3: begin en[0] = 1'b1; sx[1] = 7; en[1] = 1'b1; end
            4: begin sx[0] = 60; sy[0] = 28; en[0] = 1'b1; end
            default: begin
                for (int i = 0; i < NS; i++) begin
                    sx[i] = $urandom_range(0, 63);
                    sy[i] = $urandom_range(0, 31);
                    en[i] = ($urandom_range(0, 3) != 0);
                end
            end
        endcase
    endtask

    task automatic drawColours();
        for (int i = 0; i < NS; i++) begin
            sprRgb[i] = ($urandom_range(0, 3) == 0) ? TR : 24'($urandom);
        end
        bgCol = 24'($urandom);
        if (epoch == 0 && (cur == 0 || cur == 4)) begin
            sprRgb[0] = (cur == 0) ? 24'h00FF00 : 24'h0000FF;
            bgCol     = 24'h202020;
        end
        if (epoch == 0 && cur == 1) begin
            sprRgb[0] = TR;
            sprRgb[1] = 24'hFF0000;
        end
    endtask

    // Issue pix_en pulses (never two in a row, occasional extra gap) until
    // the requested number has been issued; sprites move only in v-blank.
    task automatic runPixels(input int target);
        for (int c = 0; c < 8 * target && np < target; c++) begin
            @(negedge clk);
            if (pix_en) pix_en = 1'b0;
            else        pix_en = ($urandom_range(0, 7) != 0);
            if (pix_en) begin
                np++;
                if (epoch == 0 && ((np + 10) % FRAME) == 0) begin
                    cur = (np + 10) / FRAME;
                    setScenario(cur);
                end
            end
            drawColours();
            applyStimulus();
        end
    endtask

    function automatic logic [NS-1:0] hitsAt(input int h, input int v);
        logic [NS-1:0] r;
        r = '0;
        for (int i = 0; i < NS; i++) begin
            r[i] = en[i] && (h < HA) && (v < VA)
                && (h >= sx[i]) && (h < sx[i] + SW)
                && (v >= sy[i]) && (v < sy[i] + SH);
        end
        return r;
    endfunction

    // Reference model and compare process.
    initial begin : compareProc
        int k, p0, p1, h0, v0, h1, v1, fr1, lastFs, hsLow, vsLow, blankHigh;
        logic [NS-1:0] prevHit, curHit, acc;
        logic [XW-1:0] eX;
        logic [YW-1:0] eY;
        logic [NS*3-1:0] eLx, eLy;
        logic eFs, eFd, eHs, eVs, eBl;
        logic [23:0] eRgb;
        logic [NS-1:0] eColl;
        k = 0;
        lastFs = -1;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                k = 0; acc = '0; prevHit = '0; lastFs = -1;
                hsLow = 0; vsLow = 0; blankHigh = 0;
                eX = '0; eY = '0; eLx = '0; eLy = '0; eFs = 0; eFd = 0;
                eHs = 1; eVs = 1; eBl = 0; eRgb = '0; eColl = '0;
            end else if (pix_en) begin
                k++;
                p0 = k - 1;
                h0 = p0 % HT;
                v0 = (p0 / HT) % VT;
                eX  = (h0 < HA && v0 < VA) ? XW'(h0) : '0;
                eY  = (h0 < HA && v0 < VA) ? YW'(v0) : '0;
                for (int i = 0; i < NS; i++) begin
                    eLx[i*3 +: 3] = 3'(h0 - sx[i]);
                    eLy[i*3 +: 3] = 3'(v0 - sy[i]);
                end
                eFs = (p0 % FRAME) == 0;
                eFd = (p0 % FRAME) == FD;
                curHit = hitsAt(h0, v0);
                if (k >= 2) begin
                    p1 = k - 2;
                    h1 = p1 % HT;
                    v1 = (p1 / HT) % VT;
                    fr1 = p1 / FRAME;
                    eHs = !(h1 >= HA + HF && h1 < HA + HF + HS);
                    eVs = !(v1 >= VA + VF && v1 < VA + VF + VS);
                    eBl = (h1 < HA && v1 < VA);
                    eRgb = bgCol;
                    for (int i = NS - 1; i >= 0; i--) begin
                        if (prevHit[i] && sprRgb[i] != TR) eRgb = sprRgb[i];
                    end
                    if (!eBl) eRgb = '0;
                    if ((p1 % FRAME) == FD) begin
                        eColl = acc;
                        acc = '0;
                    end else if ($countones(prevHit) >= 2) begin
                        acc = acc | prevHit;
                    end
                    if (epoch == 0) begin
                        if (fr1 == 0 && h1 == 10 && v1 == 5)  checkOutput("lit_green", vga_rgb, 24'h00FF00);
                        if (fr1 == 0 && h1 == 18 && v1 == 5)  checkOutput("lit_bg_right", vga_rgb, 24'h202020);
                        if (fr1 == 0 && h1 == 9 && v1 == 5)   checkOutput("lit_latency", vga_rgb, 24'h202020);
                        if (fr1 == 1 && h1 == 30 && v1 == 12) checkOutput("lit_red_overlap", vga_rgb, 24'hFF0000);
                        if (fr1 == 4 && h1 == 60 && v1 == 28) checkOutput("lit_edge_corner", vga_rgb, 24'h0000FF);
                        if (fr1 == 4 && h1 == 63 && v1 == 31) checkOutput("lit_edge_last", vga_rgb, 24'h0000FF);
                        if (fr1 == 4 && h1 == 59 && v1 == 28) checkOutput("lit_edge_left", vga_rgb, 24'h202020);
                        if ((p1 % FRAME) == FD) begin
                            if (fr1 == 0) checkOutput("lit_coll_single", coll_mask, 3'b000);
                            if (fr1 == 1) checkOutput("lit_coll_overlap", coll_mask, 3'b011);
                            if (fr1 == 2) checkOutput("lit_coll_adjacent", coll_mask, 3'b000);
                            if (fr1 == 3) checkOutput("lit_coll_touch", coll_mask, 3'b011);
                        end
                        if (fr1 == 1) begin
                            hsLow     += (vga_hs == 1'b0);
                            vsLow     += (vga_vs == 1'b0);
                            blankHigh += (vga_blank_n == 1'b1);
                        end
                        if (p1 == 2 * FRAME) begin
                            checkOutput("lit_hs_low_count", hsLow, HS * VT);
                            checkOutput("lit_vs_low_count", vsLow, VS * HT);
                            checkOutput("lit_blank_count", blankHigh, HA * VA);
                        end
                    end
                end
                prevHit = curHit;
                if (epoch == 0 && frame_start) begin
                    if (lastFs >= 0) checkOutput("lit_fs_period", k - lastFs, FRAME);
                    lastFs = k;
                end
                if (epoch == 1 && k == 1) checkOutput("lit_fs_after_reset", frame_start, 1'b1);
            end
            checkOutput("pix_x", pix_x, eX);
            checkOutput("pix_y", pix_y, eY);
            checkOutput("spr_lx", spr_lx, eLx);
            checkOutput("spr_ly", spr_ly, eLy);
            checkOutput("frame_start", frame_start, eFs);
            checkOutput("frame_done", frame_done, eFd);
            checkOutput("vga_hs", vga_hs, eHs);
            checkOutput("vga_vs", vga_vs, eVs);
            checkOutput("vga_blank_n", vga_blank_n, eBl);
            checkOutput("vga_rgb", vga_rgb, eRgb);
            checkOutput("coll_mask", coll_mask, eColl);
        end
    end

    initial begin : stimulusProc
        rst    = 1'b0;
        pix_en = 1'b0;
        setScenario(0);
        drawColours();
        applyStimulus();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        $display("[TB] first run: eight frames, then reset mid-frame");
        runPixels(8 * FRAME + 16 * HT + 32 + 1);
        @(negedge clk);
        pix_en = 1'b0;
        rst    = 1'b0;
        #1;
        checkOutput("rst_pix_x", pix_x, 0);
        checkOutput("rst_pix_y", pix_y, 0);
        checkOutput("rst_rgb", vga_rgb, 0);
        checkOutput("rst_blank", vga_blank_n, 1'b0);
        checkOutput("rst_hs", vga_hs, 1'b1);
        checkOutput("rst_vs", vga_vs, 1'b1);
        checkOutput("rst_coll", coll_mask, 0);
        checkOutput("rst_pulses", {frame_start, frame_done}, 2'b00);
        repeat (3) @(negedge clk);
        epoch = 1;
        np    = 0;
        cur   = 99;
        setScenario(cur);
        applyStimulus();
        @(negedge clk);
        rst = 1'b1;
        $display("[TB] second run after mid-frame reset");
        runPixels(FRAME + FRAME / 4);
        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
